program_loader: RTL and testbench

//   Loads a program into the instruction store that the Processor fetches from.

---
 rtl/program_loader.sv | 116 +++++++++++
 tb/tb_program_loader.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// Framed byte-stream loader for the Processor's instruction store.
// Frames carry a length byte, big-endian 16-bit words and an XOR checksum.
module program_loader #(
   parameter int DEPTH  = 8,
   parameter int ADDR_W = 3,
   parameter int IW     = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [7:0]        byte_in,
   input  logic              byte_valid,
   output logic              byte_ready,
   input  logic [ADDR_W-1:0] fetch_addr,
   output logic [IW-1:0]     fetch_data,
   output logic [ADDR_W:0]   word_count,
   output logic              load_done,
   output logic              load_error,
   output logic              cpu_hold
);

   typedef enum logic [2:0] {
      IDLE,
      LEN,
      HI,
      LO,
      CSUM,
      DONE,
      ERR
   } state_t;

   state_t state;
   state_t next_state;

   logic [7:0]      len_reg;
   logic [7:0]      csum;
   logic [7:0]      hi_byte;
   logic [IW-1:0]   mem [DEPTH];

   logic            xfer;
   logic            len_ok;
   logic            idle_like;
   logic [ADDR_W:0] wc_next;

   assign xfer      = byte_valid && byte_ready;
   assign len_ok    = (byte_in != 8'd0) && (byte_in <= 8'(DEPTH));
   assign idle_like = (state == IDLE) || (state == DONE) || (state == ERR);
   assign wc_next   = word_count + 1'b1;

   always_comb begin
      next_state = state;
      case (state)
         IDLE, DONE, ERR: if (start) next_state = LEN;
         LEN:             if (xfer) next_state = len_ok ? HI : ERR;
         HI:              if (xfer) next_state = LO;
         LO:              if (xfer) next_state = (8'(wc_next) == len_reg) ? CSUM : HI;
         CSUM:            if (xfer) next_state = (byte_in == csum) ? DONE : ERR;
         default:         next_state = IDLE;
      endcase
   end

   // Status outputs are decoded from the next state so they line up with it.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         byte_ready <= 1'b0;
         load_done  <= 1'b0;
         load_error <= 1'b0;
         cpu_hold   <= 1'b1;
      end else begin
         state      <= next_state;
         byte_ready <= (next_state == LEN) || (next_state == HI) ||
                       (next_state == LO)  || (next_state == CSUM);
         load_done  <= (next_state == DONE);
         load_error <= (next_state == ERR);
         cpu_hold   <= (next_state != DONE);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         word_count <= '0;
         csum       <= 8'd0;
         len_reg    <= 8'd0;
         hi_byte    <= 8'd0;
         fetch_data <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         fetch_data <= mem[fetch_addr];
         if (idle_like && start) begin
            word_count <= '0;
            csum       <= 8'd0;
         end else if (xfer) begin
            case (state)
               LEN: begin
                  len_reg <= byte_in;
                  csum    <= byte_in;
               end
               HI: begin
                  hi_byte <= byte_in;
                  csum    <= csum ^ byte_in;
               end
               LO: begin
                  mem[word_count[ADDR_W-1:0]] <= {hi_byte, byte_in};
                  word_count                  <= wc_next;
                  csum                        <= csum ^ byte_in;
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: fixed frame table, hand-built
// corner sequences and random frames checked against a frame-level model.
module tb_program_loader;

   localparam int DEPTH  = 8;
   localparam int ADDR_W = 3;
   localparam int IW     = 16;

   logic              clk = 1'b0;
   logic              reset;
   logic              start;
   logic [7:0]        byte_in;
   logic              byte_valid;
   logic              byte_ready;
   logic [ADDR_W-1:0] fetch_addr;
   logic [IW-1:0]     fetch_data;
   logic [ADDR_W:0]   word_count;
   logic              load_done;
   logic              load_error;
   logic              cpu_hold;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   program_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .IW(IW)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .byte_in    (byte_in),
      .byte_valid (byte_valid),
      .byte_ready (byte_ready),
      .fetch_addr (fetch_addr),
      .fetch_data (fetch_data),
      .word_count (word_count),
      .load_done  (load_done),
      .load_error (load_error),
      .cpu_hold   (cpu_hold)
   );

   typedef struct {
      string        name;
      logic [143:0] bytes;
      int           nbytes;
      bit           gaps;
      bit           exp_done;
      bit           exp_err;
      int           exp_wc;
   } vec_t;

   vec_t       vecs[6];
   logic [7:0] frame_q[$];
   logic [15:0] mem_m [DEPTH];
   bit         m_done;
   bit         m_err;
   int         m_wc;

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   // Whole-frame reference: decides the outcome from the byte list alone.
   task automatic model_frame();
      int n;
      logic [7:0] x;
      n      = int'(frame_q[0]);
      x      = frame_q[0];
      m_done = 1'b0;
      m_err  = 1'b0;
      m_wc   = 0;
      if (n < 1 || n > DEPTH) begin
         m_err = 1'b1;
         return;
      end
      for (int i = 0; i < n; i++) begin
         mem_m[i] = {frame_q[1 + 2*i], frame_q[2 + 2*i]};
         x = x ^ frame_q[1 + 2*i] ^ frame_q[2 + 2*i];
      end
      m_wc = n;
      if (frame_q[2*n + 1] == x) m_done = 1'b1;
      else                       m_err  = 1'b1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input bit gaps);
      int waits;
      waits = 0;
      if (gaps) begin
         repeat ($urandom_range(0, 3)) begin
            byte_valid = 1'b0;
            byte_in    = 8'($urandom);
            @(negedge clk);
         end
      end
      byte_in    = b;
      byte_valid = 1'b1;
      while (!byte_ready && waits < 20) begin
         @(negedge clk);
         waits++;
      end
      if (!byte_ready) begin
         check("ready_timeout", 32'(byte_ready), 32'd1);
         byte_valid = 1'b0;
         return;
      end
      @(negedge clk);
      byte_valid = 1'b0;
   endtask

   task automatic garbage(input int cycles);
      byte_valid = 1'b1;
      repeat (cycles) begin
         byte_in = 8'($urandom);
         @(negedge clk);
      end
      byte_valid = 1'b0;
   endtask

   task automatic run_frame(input bit do_start, input bit gaps);
      if (do_start) pulse_start();
      foreach (frame_q[i]) send_byte(frame_q[i], gaps);
      model_frame();
   endtask

   task automatic check_status(input string name);
      check({name, ".done"},  32'(load_done),  32'(m_done));
      check({name, ".error"}, 32'(load_error), 32'(m_err));
      check({name, ".hold"},  32'(cpu_hold),   32'(!m_done));
      check({name, ".wc"},    32'(word_count), 32'(m_wc));
      check({name, ".ready"}, 32'(byte_ready), 32'd0);
   endtask

   task automatic check_mem(input string name);
      for (int a = 0; a < DEPTH; a++) begin
         fetch_addr = ADDR_W'(a);
         @(negedge clk);
         check($sformatf("%s.mem%0d", name, a), 32'(fetch_data), 32'(mem_m[a]));
      end
   endtask

   task automatic apply_stimulus(input vec_t v);
      frame_q.delete();
      for (int i = 0; i < v.nbytes; i++) frame_q.push_back(v.bytes[143 - 8*i -: 8]);
      run_frame(1'b1, v.gaps);
   endtask

   task automatic check_output(input vec_t v);
      check({v.name, ".done"},  32'(load_done),  32'(v.exp_done));
      check({v.name, ".error"}, 32'(load_error), 32'(v.exp_err));
      check({v.name, ".hold"},  32'(cpu_hold),   32'(!v.exp_done));
      check({v.name, ".wc"},    32'(word_count), 32'(v.exp_wc));
      check({v.name, ".ready"}, 32'(byte_ready), 32'd0);
      check_mem(v.name);
   endtask

   task automatic load_test1();
      frame_q = '{8'h02, 8'h00, 8'h12, 8'h01, 8'h34, 8'h25};
   endtask

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int len;
      logic [7:0] x;

      vecs[0] = '{"good",    {8'h02, 8'h00, 8'h12, 8'h01, 8'h34, 8'h25, 96'h0}, 6, 1'b0, 1'b1, 1'b0, 2};
      vecs[1] = '{"badcsum", {8'h02, 8'h00, 8'h12, 8'h01, 8'h34, 8'h26, 96'h0}, 6, 1'b0, 1'b0, 1'b1, 2};
      vecs[2] = '{"len0",    {8'h00, 136'h0}, 1, 1'b0, 1'b0, 1'b1, 0};
      vecs[3] = '{"len9",    {8'h09, 136'h0}, 1, 1'b0, 1'b0, 1'b1, 0};
      vecs[4] = '{"gapped",  {8'h02, 8'h00, 8'h12, 8'h01, 8'h34, 8'h25, 96'h0}, 6, 1'b1, 1'b1, 1'b0, 2};
      vecs[5] = '{"depth8",  {8'h08, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08,
                              8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F, 8'h10, 8'h18},
                  18, 1'b1, 1'b1, 1'b0, 8};

      reset      = 1'b1;
      start      = 1'b0;
      byte_valid = 1'b0;
      byte_in    = 8'h00;
      fetch_addr = '0;
      for (int i = 0; i < DEPTH; i++) mem_m[i] = 16'h0000;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      check("reset.ready", 32'(byte_ready), 32'd0);
      check("reset.done",  32'(load_done),  32'd0);
      check("reset.error", 32'(load_error), 32'd0);
      check("reset.hold",  32'(cpu_hold),   32'd1);
      check("reset.wc",    32'(word_count), 32'd0);
      check("reset.fetch", 32'(fetch_data), 32'd0);
      check_mem("reset");

      for (int i = 0; i < 6; i++) begin
         apply_stimulus(vecs[i]);
         check_output(vecs[i]);
      end

      // Bytes offered while the loader is not ready must be ignored.
      frame_q = '{8'h09};
      run_frame(1'b1, 1'b0);
      garbage(5);
      check_status("err_garbage");
      check_mem("err_garbage");

      // Reset in the middle of a frame discards it and clears the store.
      load_test1();
      pulse_start();
      for (int i = 0; i < 3; i++) send_byte(frame_q[i], 1'b0);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_m[i] = 16'h0000;
      check("midrst.ready", 32'(byte_ready), 32'd0);
      check("midrst.done",  32'(load_done),  32'd0);
      check("midrst.error", 32'(load_error), 32'd0);
      check("midrst.hold",  32'(cpu_hold),   32'd1);
      check("midrst.wc",    32'(word_count), 32'd0);
      check("midrst.fetch", 32'(fetch_data), 32'd0);
      check_mem("midrst");
      run_frame(1'b1, 1'b0);
      check_status("after_rst");
      check_mem("after_rst");

      // A start pulse during a frame changes nothing.
      pulse_start();
      for (int i = 0; i < 3; i++) send_byte(frame_q[i], 1'b0);
      pulse_start();
      check("midstart.ready", 32'(byte_ready), 32'd1);
      check("midstart.wc",    32'(word_count), 32'd1);
      for (int i = 3; i < 6; i++) send_byte(frame_q[i], 1'b0);
      model_frame();
      check_status("midstart");
      check_mem("midstart");

      // Start from DONE re-arms the loader and holds the core again.
      pulse_start();
      check("restart.hold",  32'(cpu_hold),   32'd1);
      check("restart.done",  32'(load_done),  32'd0);
      check("restart.ready", 32'(byte_ready), 32'd1);
      check("restart.wc",    32'(word_count), 32'd0);
      frame_q = '{8'h01, 8'hAB, 8'hCD, 8'h67};
      run_frame(1'b0, 1'b0);
      check_status("restart");
      check_mem("restart");
      garbage(4);
      check_status("done_garbage");
      check_mem("done_garbage");

      for (int it = 0; it < 25; it++) begin
         frame_q.delete();
         if ($urandom_range(0, 9) == 0) begin
            len = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(9, 255));
            frame_q.push_back(8'(len));
         end else begin
            len = int'($urandom_range(1, DEPTH));
            frame_q.push_back(8'(len));
            x = 8'(len);
            for (int b = 0; b < 2*len; b++) begin
               frame_q.push_back(8'($urandom));
               x = x ^ frame_q[frame_q.size() - 1];
            end
            if ($urandom_range(0, 3) == 0) x = x ^ 8'(1 << $urandom_range(0, 7));
            frame_q.push_back(x);
         end
         run_frame(1'b1, 1'b1);
         check_status($sformatf("rand%0d", it));
         check_mem($sformatf("rand%0d", it));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
